my_ave_window: RTL and testbench

//  Upstream feeder for the 7-input averager (a..g -> h, 2-clock latency).

---
 rtl/my_ave_window.sv | 130 +++++++++++++
 tb/tb_my_ave_window.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/my_ave_window.sv
// my_ave_window: collects a serial stream of signed samples into a 7-deep window
// that feeds the 7-input averager (a = oldest ... g = newest).
// MODE 0 strobes win_valid on every sample once the window is full.
// MODE 1 strobes win_valid once per non-overlapping block of 7 samples.
// Optional feature: define AVE_VALID_PIPE_EN to add ave_valid, which is
// win_valid delayed by 2 clocks to line up with the averager's output.
module my_ave_window #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 7,
  parameter int unsigned MODE   = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic                     flush,
  output logic signed [DATA_W-1:0] a,
  output logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] c,
  output logic signed [DATA_W-1:0] d,
  output logic signed [DATA_W-1:0] e,
  output logic signed [DATA_W-1:0] f,
  output logic signed [DATA_W-1:0] g,
  output logic                     win_valid,
  output logic [2:0]               fill_cnt
`ifdef AVE_VALID_PIPE_EN
  ,
  output logic                     ave_valid
`endif
);

  typedef enum logic [1:0] {StEmpty, StFill, StFull, StFlush} state_e;

  localparam logic [2:0] LastCnt = 3'(DEPTH - 1);
  localparam logic [2:0] FullCnt = 3'(DEPTH);

  state_e                     state_q;
  logic signed [DATA_W-1:0]   win_q [DEPTH];
  logic [2:0]                 fill_cnt_q;
  logic                       win_valid_q;
  logic                       xfer;

  // Flush blocks the input immediately and for the whole FLUSH cycle.
  assign s_ready = !flush && (state_q != StFlush);
  assign xfer    = s_valid && s_ready;

  // Window shift register, fill counter, FSM and registered strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) win_q[i] <= '0;
      fill_cnt_q  <= '0;
      win_valid_q <= 1'b0;
      state_q     <= StEmpty;
    end else if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) win_q[i] <= '0;
      fill_cnt_q  <= '0;
      win_valid_q <= 1'b0;
      state_q     <= StFlush;
    end else begin
      win_valid_q <= 1'b0;
      if (xfer) begin
        for (int unsigned i = 0; i < DEPTH - 1; i++) win_q[i] <= win_q[i+1];
        win_q[DEPTH-1] <= s_data;
      end
      unique case (state_q)
        StFlush: state_q <= StEmpty;
        StEmpty: begin
          if (xfer) begin
            fill_cnt_q <= 3'd1;
            state_q    <= StFill;
          end
        end
        StFill: begin
          if (xfer) begin
            fill_cnt_q <= fill_cnt_q + 3'd1;
            if (fill_cnt_q == LastCnt) begin
              state_q     <= StFull;
              win_valid_q <= 1'b1;
            end
          end
        end
        StFull: begin
          if (MODE == 0) begin
            // Sliding: every new sample completes a fresh window.
            fill_cnt_q <= FullCnt;
            if (xfer) win_valid_q <= 1'b1;
          end else if (xfer) begin
            // Block: a sample arriving in the strobe cycle opens the next block;
            // older words stay stale until overwritten.
            fill_cnt_q <= 3'd1;
            state_q    <= StFill;
          end else begin
            fill_cnt_q <= '0;
            state_q    <= StEmpty;
          end
        end
        default: state_q <= StEmpty;
      endcase
    end
  end

  assign a         = win_q[0];
  assign b         = win_q[1];
  assign c         = win_q[2];
  assign d         = win_q[3];
  assign e         = win_q[4];
  assign f         = win_q[5];
  assign g         = win_q[6];
  assign win_valid = win_valid_q;
  assign fill_cnt  = fill_cnt_q;

`ifdef AVE_VALID_PIPE_EN
  logic [1:0] pipe_q;

  // Two-stage delay of win_valid matching the averager latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= '0;
    end else if (flush) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= {pipe_q[0], win_valid_q};
    end
  end

  assign ave_valid = pipe_q[1];
`endif

endmodule

// File: tb/tb_my_ave_window.sv
// Bench for my_ave_window: one sliding-mode and one block-mode instance.
// Expected windows go into per-instance queues; monitors pop on win_valid.
module tb_my_ave_window;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic signed [W-1:0] s_data0, s_data1;
  logic s_valid0, s_valid1, flush0, flush1;
  logic s_ready0, s_ready1, wv0, wv1;
  logic signed [W-1:0] a0, b0, c0, d0, e0, f0, g0;
  logic signed [W-1:0] a1, b1, c1, d1, e1, f1, g1;
  logic [2:0] fc0, fc1;
`ifdef AVE_VALID_PIPE_EN
  logic av0, av1;
`endif

  int total = 0;
  int bad   = 0;
  logic [7*W-1:0] q0[$];
  logic [7*W-1:0] q1[$];
  logic [7*W-1:0] exp0, exp1, got0, got1;

  my_ave_window #(.DATA_W(32), .DEPTH(7), .MODE(0)) u_slide (
    .clk(clk), .rst_n(rst_n), .s_data(s_data0), .s_valid(s_valid0), .s_ready(s_ready0),
    .flush(flush0), .a(a0), .b(b0), .c(c0), .d(d0), .e(e0), .f(f0), .g(g0),
    .win_valid(wv0), .fill_cnt(fc0)
`ifdef AVE_VALID_PIPE_EN
    , .ave_valid(av0)
`endif
  );

  my_ave_window #(.DATA_W(32), .DEPTH(7), .MODE(1)) u_block (
    .clk(clk), .rst_n(rst_n), .s_data(s_data1), .s_valid(s_valid1), .s_ready(s_ready1),
    .flush(flush1), .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .f(f1), .g(g1),
    .win_valid(wv1), .fill_cnt(fc1)
`ifdef AVE_VALID_PIPE_EN
    , .ave_valid(av1)
`endif
  );

  // Window {first, first+dir, ...} packed with a (oldest) in the top word.
  function automatic logic [7*W-1:0] seq(input int first, input int dir);
    logic [7*W-1:0] r;
    for (int i = 0; i < 7; i++) r[(6-i)*W +: W] = W'(first + dir * i);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got=%0d required=%0d", nm, $signed(got), $signed(req));
    end
  endtask

  // Present one sample and hold until it is accepted; returns #1 after the edge.
  task automatic push(input bit u, input int dv);
    bit done = 1'b0;
    if (u) begin s_data1 = dv; s_valid1 = 1'b1; end
    else   begin s_data0 = dv; s_valid0 = 1'b1; end
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (u ? s_ready1 : s_ready0) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL push_timeout: unit=%0d sample=%0d not accepted in 20 cycles", u, dv);
    end
  endtask

  task automatic idle(input bit u, input int n);
    if (u) s_valid1 = 1'b0; else s_valid0 = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sliding-mode monitor.
  always @(negedge clk) begin
    if (wv0) begin
      total++;
      got0 = {a0, b0, c0, d0, e0, f0, g0};
      if (q0.size() == 0) begin
        bad++;
        $display("FAIL slide_strobe: got window=%h required=no strobe", got0);
      end else begin
        exp0 = q0.pop_front();
        if (got0 !== exp0) begin
          bad++;
          $display("FAIL slide_window: got=%h required=%h", got0, exp0);
        end
      end
    end
  end

  // Block-mode monitor.
  always @(negedge clk) begin
    if (wv1) begin
      total++;
      got1 = {a1, b1, c1, d1, e1, f1, g1};
      if (q1.size() == 0) begin
        bad++;
        $display("FAIL block_strobe: got window=%h required=no strobe", got1);
      end else begin
        exp1 = q1.pop_front();
        if (got1 !== exp1) begin
          bad++;
          $display("FAIL block_window: got=%h required=%h", got1, exp1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    s_data0 = '0; s_valid0 = 1'b0; flush0 = 1'b0;
    s_data1 = '0; s_valid1 = 1'b0; flush1 = 1'b0;
    #12;
    chk("rst_fill0", W'(fc0), 0);
    chk("rst_wv0", W'(wv0), 0);
    chk("rst_a0", a0, 0);
    chk("rst_g0", g0, 0);
    chk("rst_fill1", W'(fc1), 0);
    chk("rst_ready0", W'(s_ready0), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Sliding: 1..7 back-to-back gives first window 1..7.
    for (int i = 1; i <= 6; i++) begin
      push(1'b0, i);
      chk("s1_fill", W'(fc0), W'(i));
    end
    q0.push_back(seq(1, 1));
    push(1'b0, 7);
    chk("s1_fill7", W'(fc0), 7);
    chk("s1_a", a0, 1);
    chk("s1_g", g0, 7);

    // Sliding: 8 and 9 each produce a window.
    q0.push_back(seq(2, 1));
    push(1'b0, 8);
    q0.push_back(seq(3, 1));
    push(1'b0, 9);
    idle(1'b0, 2);
    chk("s2_a", a0, 3);
    chk("s2_g", g0, 9);
    chk("s2_fill", W'(fc0), 7);

    // Flush with simultaneous sample at fill_cnt = 5.
    flush0 = 1'b1;
    @(posedge clk); #1;
    flush0 = 1'b0;
    for (int i = 10; i <= 14; i++) push(1'b0, i);
    chk("s4_fill5", W'(fc0), 5);
    s_data0 = 99; s_valid0 = 1'b1; flush0 = 1'b1;
    #1;
    chk("s4_ready_flush", W'(s_ready0), 0);
    @(posedge clk); #1;
    flush0 = 1'b0; s_valid0 = 1'b0;
    chk("s4_fill0", W'(fc0), 0);
    chk("s4_a0", a0, 0);
    chk("s4_g0", g0, 0);
    chk("s4_ready_st", W'(s_ready0), 0);
    @(posedge clk); #1;
    chk("s4_ready_back", W'(s_ready0), 1);

    // Gapped negative samples: single strobe, sign intact.
    for (int k = 0; k < 7; k++) begin
      if (k == 6) q0.push_back(seq(-3, -1));
      push(1'b0, -(3 + k));
      chk("s5_fill", W'(fc0), W'(k + 1));
      idle(1'b0, 1 + (k % 2));
    end
    chk("s5_a", a0, -3);
    chk("s5_d", d0, -6);
    chk("s5_g", g0, -9);

    // Block mode: 1..14 back-to-back, two strobes.
    for (int i = 1; i <= 14; i++) begin
      if (i == 7) q1.push_back(seq(1, 1));
      if (i == 14) q1.push_back(seq(8, 1));
      push(1'b1, i);
      chk("s3_fill", W'(fc1), W'((i <= 7) ? i : i - 7));
    end
    idle(1'b1, 1);
    chk("s3_fill_end", W'(fc1), 0);
    chk("s3_a", a1, 8);
    chk("s3_g", g1, 14);

`ifdef AVE_VALID_PIPE_EN
    // ave_valid lags win_valid by two cycles; window 1..7 averages to 4.
    rst_n = 1'b0;
    #2;
    chk("s6_rst_av", W'(av0), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) push(1'b0, i);
    q0.push_back(seq(1, 1));
    push(1'b0, 7);
    chk("s6_av_t0", W'(av0), 0);
    idle(1'b0, 1);
    chk("s6_av_t1", W'(av0), 0);
    idle(1'b0, 1);
    chk("s6_av_t2", W'(av0), 1);
    idle(1'b0, 1);
    chk("s6_av_t3", W'(av0), 0);
    q0.push_back(seq(2, 1));
    push(1'b0, 8);
    idle(1'b0, 1);
    idle(1'b0, 1);
    chk("s6_av_pre_rst", W'(av0), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s6_av_async", W'(av0), 0);
    chk("s6_fill_async", W'(fc0), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
`endif

    idle(1'b0, 2);
    chk("q0_drained", W'(q0.size()), 0);
    chk("q1_drained", W'(q1.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
